// File: rtl/z80fi_insn_collector.sv
// Collects the bytes, memory writes and PCs of one Z80 instruction and reports them as a one-cycle z80fi record.
// Optional read capture is built only when Z80FI_MEM_RD_EN is defined.
module z80fi_insn_collector (
    input  logic        clk,
    input  logic        reset,
    input  logic        insn_start,
    input  logic [15:0] cpu_pc,
    input  logic        byte_valid,
    input  logic [7:0]  byte_data,
    input  logic        mem_wr_valid,
    input  logic [15:0] mem_wr_addr,
    input  logic [7:0]  mem_wr_data,
    input  logic        insn_done,
    input  logic [15:0] cpu_pc_next,
`ifdef Z80FI_MEM_RD_EN
    input  logic        mem_rd_valid,
    input  logic [15:0] mem_rd_addr,
    input  logic [7:0]  mem_rd_data,
    output logic        z80fi_mem_rd,
    output logic [15:0] z80fi_mem_raddr,
    output logic [15:0] z80fi_mem_rdata,
`endif
    output logic        z80fi_valid,
    output logic [31:0] z80fi_insn,
    output logic [2:0]  z80fi_insn_len,
    output logic [15:0] z80fi_pc_rdata,
    output logic [15:0] z80fi_pc_wdata,
    output logic        z80fi_mem_wr,
    output logic [15:0] z80fi_mem_waddr,
    output logic [15:0] z80fi_mem_wdata,
    output logic        z80fi_mem_wr2,
    output logic [15:0] z80fi_mem_waddr2,
    output logic [15:0] z80fi_mem_wdata2,
    output logic        collect_err
);

    localparam int unsigned MAX_LEN = 4;

    typedef enum logic {IDLE, COLLECT} state_t;

    state_t      state_q;
    logic [31:0] insn_q, insn_d;
    logic [2:0]  len_q, len_d;
    logic [15:0] pc_q;
    logic [1:0]  wr_cnt_q, wr_cnt_d;
    logic [15:0] wr1_addr_q, wr1_addr_d, wr2_addr_q, wr2_addr_d;
    logic [7:0]  wr1_data_q, wr1_data_d, wr2_data_q, wr2_data_d;
    logic        ovf_c, err_set_c, retire_c, new_owns_c;
`ifdef Z80FI_MEM_RD_EN
    logic        rd_q, rd_d;
    logic [15:0] raddr_q, raddr_d;
    logic [7:0]  rdata_q, rdata_d;
`endif

    // Current instruction merged with this cycle's events; a byte seen with insn_start belongs to the new one.
    always_comb begin
        insn_d     = insn_q;
        len_d      = len_q;
        wr_cnt_d   = wr_cnt_q;
        wr1_addr_d = wr1_addr_q;
        wr1_data_d = wr1_data_q;
        wr2_addr_d = wr2_addr_q;
        wr2_data_d = wr2_data_q;
        ovf_c      = 1'b0;
        if (byte_valid && !insn_start) begin
            if (len_q == 3'(MAX_LEN)) begin
                ovf_c = 1'b1;
            end else begin
                case (len_q[1:0])
                    2'd0:    insn_d[7:0]   = byte_data;
                    2'd1:    insn_d[15:8]  = byte_data;
                    2'd2:    insn_d[23:16] = byte_data;
                    default: insn_d[31:24] = byte_data;
                endcase
                len_d = len_q + 3'd1;
            end
        end
        if (mem_wr_valid) begin
            case (wr_cnt_q)
                2'd0: begin
                    wr1_addr_d = mem_wr_addr;
                    wr1_data_d = mem_wr_data;
                    wr_cnt_d   = 2'd1;
                end
                2'd1: begin
                    wr2_addr_d = mem_wr_addr;
                    wr2_data_d = mem_wr_data;
                    wr_cnt_d   = 2'd2;
                end
                default: ovf_c = 1'b1;
            endcase
        end
`ifdef Z80FI_MEM_RD_EN
        rd_d    = rd_q;
        raddr_d = raddr_q;
        rdata_d = rdata_q;
        if (mem_rd_valid) begin
            if (rd_q) begin
                ovf_c = 1'b1;
            end else begin
                rd_d    = 1'b1;
                raddr_d = mem_rd_addr;
                rdata_d = mem_rd_data;
            end
        end
`endif
        retire_c   = (state_q == COLLECT) && insn_done;
        // Memory events in a retire cycle belong to the retiring instruction.
        new_owns_c = !retire_c;
        err_set_c  = ((state_q == IDLE) && insn_done) ||
                     ((state_q == COLLECT) && (ovf_c || (insn_start && !insn_done)));
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q          <= IDLE;
            insn_q           <= '0;
            len_q            <= '0;
            pc_q             <= '0;
            wr_cnt_q         <= '0;
            wr1_addr_q       <= '0;
            wr1_data_q       <= '0;
            wr2_addr_q       <= '0;
            wr2_data_q       <= '0;
            z80fi_valid      <= 1'b0;
            z80fi_insn       <= '0;
            z80fi_insn_len   <= '0;
            z80fi_pc_rdata   <= '0;
            z80fi_pc_wdata   <= '0;
            z80fi_mem_wr     <= 1'b0;
            z80fi_mem_waddr  <= '0;
            z80fi_mem_wdata  <= '0;
            z80fi_mem_wr2    <= 1'b0;
            z80fi_mem_waddr2 <= '0;
            z80fi_mem_wdata2 <= '0;
            collect_err      <= 1'b0;
`ifdef Z80FI_MEM_RD_EN
            rd_q             <= 1'b0;
            raddr_q          <= '0;
            rdata_q          <= '0;
            z80fi_mem_rd     <= 1'b0;
            z80fi_mem_raddr  <= '0;
            z80fi_mem_rdata  <= '0;
`endif
        end else begin
            z80fi_valid <= 1'b0;
            if (err_set_c) begin
                collect_err <= 1'b1;
            end
            if (retire_c) begin
                z80fi_valid      <= 1'b1;
                z80fi_insn       <= insn_d;
                z80fi_insn_len   <= len_d;
                z80fi_pc_rdata   <= pc_q;
                z80fi_pc_wdata   <= cpu_pc_next;
                z80fi_mem_wr     <= (wr_cnt_d != 2'd0);
                z80fi_mem_waddr  <= wr1_addr_d;
                z80fi_mem_wdata  <= {8'h00, wr1_data_d};
                z80fi_mem_wr2    <= (wr_cnt_d == 2'd2);
                z80fi_mem_waddr2 <= wr2_addr_d;
                z80fi_mem_wdata2 <= {8'h00, wr2_data_d};
`ifdef Z80FI_MEM_RD_EN
                z80fi_mem_rd     <= rd_d;
                z80fi_mem_raddr  <= raddr_d;
                z80fi_mem_rdata  <= {8'h00, rdata_d};
`endif
            end
            if (insn_start) begin
                state_q    <= COLLECT;
                pc_q       <= cpu_pc;
                insn_q     <= {24'h000000, byte_valid ? byte_data : 8'h00};
                len_q      <= byte_valid ? 3'd1 : 3'd0;
                wr_cnt_q   <= (mem_wr_valid && new_owns_c) ? 2'd1 : 2'd0;
                wr1_addr_q <= (mem_wr_valid && new_owns_c) ? mem_wr_addr : 16'h0000;
                wr1_data_q <= (mem_wr_valid && new_owns_c) ? mem_wr_data : 8'h00;
                wr2_addr_q <= '0;
                wr2_data_q <= '0;
`ifdef Z80FI_MEM_RD_EN
                rd_q       <= mem_rd_valid && new_owns_c;
                raddr_q    <= (mem_rd_valid && new_owns_c) ? mem_rd_addr : 16'h0000;
                rdata_q    <= (mem_rd_valid && new_owns_c) ? mem_rd_data : 8'h00;
`endif
            end else if (state_q == COLLECT) begin
                if (insn_done) begin
                    state_q <= IDLE;
                end else begin
                    insn_q     <= insn_d;
                    len_q      <= len_d;
                    wr_cnt_q   <= wr_cnt_d;
                    wr1_addr_q <= wr1_addr_d;
                    wr1_data_q <= wr1_data_d;
                    wr2_addr_q <= wr2_addr_d;
                    wr2_data_q <= wr2_data_d;
`ifdef Z80FI_MEM_RD_EN
                    rd_q       <= rd_d;
                    raddr_q    <= raddr_d;
                    rdata_q    <= rdata_d;
`endif
                end
            end
        end
    end

endmodule
